w_fetch: RTL and testbench
==========================

// Module: w_fetch
// PURPOSE
//  Weight-fetch stage directly downstream of the weight memory (mem_w). Given a start address and a word count,
//  issues sequential reads, absorbs the memory's 1-cycle read latency and streams the WIDTH-bit weight words to
//  the PE array over a valid/ready interface. Credit-based issue guarantees that back-pressure never drops a word.
// PARAMETERS
//  WIDTH       64  weight word width; equals the memory word width
//  ADDR_W      32  memory address width
//  LEN_W       16  width of the word-count field
//  FIFO_DEPTH  2   output skid FIFO entries; must be >= 2; sets maximum reads in flight plus buffered words
// PORTS
//  clk          in   1       single clock; all logic acts on the rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       one-cycle request; accepted only when busy=0
//  base_addr    in   ADDR_W  first word address, sampled when start is accepted
//  num_words    in   LEN_W   number of words to fetch, sampled when start is accepted
//  busy         out  1       high from the cycle after start is accepted until done
//  done         out  1       one-cycle pulse when the request completes
//  mem_write_en out  1       tied to 0; this block only reads the memory
//  mem_addr     out  ADDR_W  read address presented to the memory
//  mem_data_out in   WIDTH   memory read data, valid 1 cycle after the address is issued
//  w_valid      out  1       output word valid (head of the FIFO)
//  w_ready      in   1       consumer ready
//  w_data       out  WIDTH   output weight word
//  w_last       out  1       marks the final word of the request; qualified by w_valid
// BEHAVIOUR
//  - Reset: busy=0, done=0, w_valid=0, w_last=0, w_data=0, mem_addr=0; FIFO, in-flight flag and counters cleared.
//    A reset during a transfer aborts it immediately: in-flight read data is discarded and done is not pulsed.
//  - FSM states:
//    - IDLE: waits for start; on start, latch addr/remaining; goes to FETCH, or to DONE if num_words=0.
//    - FETCH: issues reads until the issue count equals num_words, then goes to DRAIN.
//    - DRAIN: waits until the FIFO is empty and no read is in flight, then goes to DONE.
//    - DONE: pulses done for 1 cycle, then returns to IDLE.
//    - busy=1 in FETCH and DRAIN only.
//    - The memory read port is free-running (it reads every cycle while write_en=0). The block must track issued
//      reads with its own 1-cycle-delayed rd_issue flag; mem_data_out is pushed into the FIFO only when that flag is set.
//  - Issue rule (one read per cycle max): issue when remaining>0 and (occ + inflight - pop) < FIFO_DEPTH,
//    where pop = w_valid & w_ready this cycle.
//    - This gives a sustained rate of 1 word/cycle when w_ready is held high, and no FIFO overflow under any w_ready pattern.
//  - Addressing:
//    - mem_addr = base_addr + issue_index, wrapping modulo 2^ADDR_W.
//    - When not issuing, mem_addr holds its last value.
//  - Latency: with w_ready=1, the first w_valid appears 2 cycles after the start cycle (1 cycle for issue, 1 cycle of memory latency).
//  - Ordering and FIFO: words come out in address order. w_data/w_valid/w_last are driven from the FIFO head.
//    A simultaneous push and pop in the same cycle is legal, including when the FIFO is full (pop frees the slot first).
//  - w_last=1 only on the word whose index is num_words-1.
//    done pulses the cycle after that word's handshake; busy falls in that same cycle.
//  - A start that arrives while busy=1 is ignored.
//    A start in the DONE cycle is also ignored; start is only accepted in IDLE.
//  - num_words=0: no reads are issued and w_valid stays 0; done pulses 1 cycle after start.
// CONFIGURATION
//  W_FETCH_BYTE_REV_EN: when defined, the byte lanes of each word are reversed on FIFO push
//    (memory byte 0 at bits [WIDTH-1:WIDTH-8] lands at w_data[7:0]), so PE lane k receives the k-th packed byte.
//    When undefined, w_data equals mem_data_out bit-exact. Timing is identical in both cases.
// TESTING
//  1. base=0, n=4, w_ready=1: mem_addr 0..3 on consecutive cycles; 4 beats back to back;
//     w_last on beat 3; done pulses once.
//  2. base=10, n=8, w_ready toggling 1010...: all 8 words arrive in order, none dropped or duplicated;
//     the count of issues never exceeds FIFO_DEPTH ahead of pops.
//  3. base=32'hFFFF_FFFE, n=4: mem_addr sequence FFFFFFFE, FFFFFFFF, 0, 1.
//  4. n=0: done pulses 1 cycle after start; w_valid is never asserted. A second start while busy is ignored.
//  5. rst asserted during beat 2 of an n=6 transfer: all outputs are 0 the next cycle, no done pulse;
//     a subsequent n=2 request completes cleanly.
//  6. Macro defined, memory word 64'h0102030405060708: w_data=64'h0807060504030201.
//     Macro undefined: w_data=64'h0102030405060708.

Source files
------------

// File: rtl/w_fetch.sv
// rtl/w_fetch.sv - weight-fetch stage: sequential mem_w reads streamed out through a credit-checked skid FIFO
// Optional feature macro W_FETCH_BYTE_REV_EN: reverse the byte lanes of each word on FIFO push.
module w_fetch #(
   parameter int WIDTH      = 64,
   parameter int ADDR_W     = 32,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_words,
   output logic              busy,
   output logic              done,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]  mem_data_out,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [WIDTH-1:0]  w_data,
   output logic              w_last
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t            state_q;
   logic              busy_q, done_q;
   logic [ADDR_W-1:0] addr_q, last_addr_q;
   logic [LEN_W-1:0]  remaining_q;
   logic              inflight_q, inflight_last_q;
   logic [WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
   logic              fifo_last_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  occ_q, occ_d, credit;

   logic              pop, push, issue, issue_ok;
   logic [LEN_W-1:0]  issue_rem;
   logic [ADDR_W-1:0] issue_addr;
   logic [WIDTH-1:0]  push_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // The first read goes out in the start cycle itself so the word reaches the FIFO two cycles later.
   assign issue_ok   = ((state_q == S_IDLE) && start) || (state_q == S_FETCH);
   assign issue_rem  = (state_q == S_IDLE) ? num_words : remaining_q;
   assign issue_addr = (state_q == S_IDLE) ? base_addr : addr_q;

   assign pop    = (occ_q != '0) && w_ready;
   assign push   = inflight_q;
   assign credit = occ_q + CNT_W'(inflight_q) - CNT_W'(pop);
   assign issue  = issue_ok && (issue_rem != '0) && (credit < CNT_W'(FIFO_DEPTH));
   assign occ_d  = occ_q + CNT_W'(push) - CNT_W'(pop);

`ifdef W_FETCH_BYTE_REV_EN
   always_comb begin
      push_data = '0;
      for (int b = 0; b < WIDTH / 8; b++)
         push_data[8*b +: 8] = mem_data_out[WIDTH-8-8*b +: 8];
   end
`else
   assign push_data = mem_data_out;
`endif

   assign mem_write_en = 1'b0;
   assign mem_addr     = issue ? issue_addr : last_addr_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign w_valid      = (occ_q != '0);
   assign w_data       = fifo_data_q[rd_ptr_q];
   assign w_last       = fifo_last_q[rd_ptr_q] && w_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         addr_q          <= '0;
         last_addr_q     <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         occ_q           <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         inflight_q      <= issue;
         inflight_last_q <= issue && (issue_rem == LEN_W'(1));
         occ_q           <= occ_d;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= ptr_inc(wr_ptr_q);
         end
         if (pop)
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (issue) begin
            last_addr_q <= issue_addr;
            addr_q      <= issue_addr + 1'b1;
            remaining_q <= issue_rem - 1'b1;
         end
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (num_words == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_FETCH;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if ((remaining_q == '0) || (issue && (remaining_q == LEN_W'(1))))
                  state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               // occ_d already counts the in-flight word, so zero means nothing is left anywhere.
               if (occ_d == '0) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_w_fetch.sv
// tb/tb_w_fetch.sv - randomized self-checking bench for w_fetch against a queue-based reference model
module tb_w_fetch;
   localparam int WIDTH = 64;
   localparam int ADDR_W = 32;
   localparam int LEN_W = 16;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, start, busy, done, mem_write_en;
   logic [31:0] base_addr, mem_addr;
   logic [15:0] num_words;
   logic [63:0] mem_data_out, w_data;
   logic        w_valid, w_ready, w_last;

   int total = 0;
   int bad = 0;
   bit const_mode = 1'b0;

   always #5 clk = ~clk;

   w_fetch #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
      .busy(busy), .done(done), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
      .mem_data_out(mem_data_out), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_last(w_last)
   );

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {~a ^ 32'h5A5A_0F0F, a * 32'h9E37_79B9 + 32'h0123_4567};
   endfunction

   function automatic logic [63:0] exp_word(input logic [63:0] raw);
`ifdef W_FETCH_BYTE_REV_EN
      return {<<8{raw}};
`else
      return raw;
`endif
   endfunction

   // Free-running synchronous read port of mem_w.
   always @(posedge clk) mem_data_out <= const_mode ? 64'h0102_0304_0506_0708 : mem_word(mem_addr);

   logic [63:0] beat_data[$];
   bit          beat_last[$];
   int          beat_cyc[$];
   logic [31:0] addr_tr[$];
   bit          busy_tr[$];
   int          done_cnt, done_cyc, issued, pops, max_ahead;
   bit          valid_seen, timed_out;

   task automatic do_xfer(input logic [31:0] base, input logic [15:0] n, input int rdy, input int poke_cyc);
      logic [31:0] next_a;
      beat_data.delete(); beat_last.delete(); beat_cyc.delete(); addr_tr.delete(); busy_tr.delete();
      done_cnt = 0; done_cyc = -1; issued = 0; pops = 0; max_ahead = 0; valid_seen = 0; timed_out = 1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         start = (c == 0) || (c == poke_cyc);
         if (c == 0) begin
            base_addr = base; num_words = n;
         end else if (c == poke_cyc) begin
            base_addr = 32'h100; num_words = 16'd3;
         end
         w_ready = (rdy < 0) ? (c % 2 == 0) : ($urandom_range(99) < rdy);
         #1;
         addr_tr.push_back(mem_addr);
         busy_tr.push_back(busy);
         if (w_valid) valid_seen = 1;
         next_a = base + 32'(issued);
         if (issued < int'(n) && mem_addr == next_a) issued++;
         if (w_valid && w_ready) begin
            beat_data.push_back(w_data); beat_last.push_back(w_last); beat_cyc.push_back(c); pops++;
         end
         if (issued - pops > max_ahead) max_ahead = issued - pops;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && c >= done_cyc + 2) begin
            timed_out = 0;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; w_ready = 1'b0; base_addr = '0; num_words = '0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", w_valid); end
      total++; if (w_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", w_last); end
      total++; if (w_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", w_data); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
      total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", mem_write_en); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_basic();
      do_xfer(32'd0, 16'd4, 100, -1);
      total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=no_done exp=done"); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (addr_tr[i] !== 32'(i)) begin bad++; $display("FAIL basic_addr%0d got=%h exp=%h", i, addr_tr[i], i); end
      end
      total++; if (beat_data.size() != 4) begin bad++; $display("FAIL basic_beats got=%0d exp=4", beat_data.size()); end
      for (int i = 0; i < beat_data.size(); i++) begin
         total++;
         if (beat_data[i] !== exp_word(mem_word(32'(i))) || beat_last[i] !== (i == 3) || beat_cyc[i] != 2 + i) begin
            bad++;
            $display("FAIL basic_beat%0d got=%h/%b@%0d exp=%h/%b@%0d", i, beat_data[i], beat_last[i], beat_cyc[i],
                     exp_word(mem_word(32'(i))), (i == 3), 2 + i);
         end
      end
      total++; if (done_cnt != 1 || done_cyc != 6) begin bad++; $display("FAIL basic_done got=%0d@%0d exp=1@6", done_cnt, done_cyc); end
      for (int c = 0; c < busy_tr.size(); c++) begin
         total++;
         if (busy_tr[c] !== (c >= 1 && c <= 5)) begin bad++; $display("FAIL basic_busy%0d got=%b exp=%b", c, busy_tr[c], (c >= 1 && c <= 5)); end
      end
   endtask

   task automatic test_backpressure();
      do_xfer(32'd10, 16'd8, -1, 2);
      total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=no_done exp=done"); end
      total++; if (beat_data.size() != 8) begin bad++; $display("FAIL bp_beats got=%0d exp=8", beat_data.size()); end
      for (int i = 0; i < beat_data.size(); i++) begin
         total++;
         if (beat_data[i] !== exp_word(mem_word(32'(10 + i))) || beat_last[i] !== (i == 7)) begin
            bad++;
            $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i], exp_word(mem_word(32'(10 + i))), (i == 7));
         end
      end
      total++; if (max_ahead > DEPTH) begin bad++; $display("FAIL bp_credit got=%0d exp<=%0d", max_ahead, DEPTH); end
      total++; if (issued != 8) begin bad++; $display("FAIL bp_issued got=%0d exp=8", issued); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); end
      if (beat_cyc.size() == 8) begin
         total++;
         if (done_cyc != beat_cyc[7] + 1) begin bad++; $display("FAIL bp_done_cyc got=%0d exp=%0d", done_cyc, beat_cyc[7] + 1); end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_a [4];
      exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
      do_xfer(32'hFFFF_FFFE, 16'd4, 100, -1);
      total++; if (timed_out) begin bad++; $display("FAIL wrap_timeout got=no_done exp=done"); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (addr_tr[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, addr_tr[i], exp_a[i]); end
      end
      total++; if (beat_data.size() != 4) begin bad++; $display("FAIL wrap_beats got=%0d exp=4", beat_data.size()); end
      for (int i = 0; i < beat_data.size(); i++) begin
         total++;
         if (beat_data[i] !== exp_word(mem_word(exp_a[i]))) begin bad++; $display("FAIL wrap_data%0d got=%h exp=%h", i, beat_data[i], exp_word(mem_word(exp_a[i]))); end
      end
   endtask

   task automatic test_zero_len();
      bit busy_seen = 0;
      do_xfer(32'd5, 16'd0, 100, 1);
      foreach (busy_tr[c]) if (busy_tr[c]) busy_seen = 1;
      total++; if (timed_out) begin bad++; $display("FAIL zero_timeout got=no_done exp=done"); end
      total++; if (done_cyc != 1 || done_cnt != 1) begin bad++; $display("FAIL zero_done got=%0d@%0d exp=1@1", done_cnt, done_cyc); end
      total++; if (valid_seen) begin bad++; $display("FAIL zero_valid got=1 exp=0"); end
      total++; if (busy_seen) begin bad++; $display("FAIL zero_busy got=1 exp=0"); end
      total++; if (issued != 0) begin bad++; $display("FAIL zero_issued got=%0d exp=0", issued); end
   endtask

   task automatic test_reset_abort();
      int late_done = 0;
      int late_valid = 0;
      @(negedge clk);
      start = 1'b1; base_addr = 32'd200; num_words = 16'd6; w_ready = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1;
      total++;
      if (w_valid !== 1'b1 || w_data !== exp_word(mem_word(32'd202))) begin
         bad++; $display("FAIL abort_beat2 got=%b/%h exp=1/%h", w_valid, w_data, exp_word(mem_word(32'd202)));
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if ({busy, done, w_valid, w_last} !== 4'b0 || w_data !== 64'h0 || mem_addr !== 32'h0) begin
         bad++; $display("FAIL abort_zero got=%b%b%b%b/%h/%h exp=0000/0/0", busy, done, w_valid, w_last, w_data, mem_addr);
      end
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (done) late_done++;
         if (w_valid) late_valid++;
      end
      total++; if (late_done != 0 || late_valid != 0) begin bad++; $display("FAIL abort_quiet got=%0d/%0d exp=0/0", late_done, late_valid); end
      do_xfer(32'd50, 16'd2, 100, -1);
      total++; if (timed_out || done_cnt != 1) begin bad++; $display("FAIL abort_next_done got=%0d exp=1", done_cnt); end
      total++; if (beat_data.size() != 2) begin bad++; $display("FAIL abort_next_beats got=%0d exp=2", beat_data.size()); end
      for (int i = 0; i < beat_data.size(); i++) begin
         total++;
         if (beat_data[i] !== exp_word(mem_word(32'(50 + i))) || beat_last[i] !== (i == 1)) begin
            bad++; $display("FAIL abort_next%0d got=%h/%b exp=%h/%b", i, beat_data[i], beat_last[i], exp_word(mem_word(32'(50 + i))), (i == 1));
         end
      end
   endtask

   task automatic test_byte_order();
      logic [63:0] exp_d;
`ifdef W_FETCH_BYTE_REV_EN
      exp_d = 64'h0807_0605_0403_0201;
`else
      exp_d = 64'h0102_0304_0506_0708;
`endif
      const_mode = 1'b1;
      do_xfer(32'd7, 16'd1, 100, -1);
      const_mode = 1'b0;
      total++; if (beat_data.size() != 1) begin bad++; $display("FAIL bytes_beats got=%0d exp=1", beat_data.size()); end
      if (beat_data.size() == 1) begin
         total++;
         if (beat_data[0] !== exp_d || beat_last[0] !== 1'b1) begin bad++; $display("FAIL bytes_data got=%h/%b exp=%h/1", beat_data[0], beat_last[0], exp_d); end
      end
   endtask

   task automatic test_random();
      logic [31:0] b;
      logic [15:0] n;
      int rdy;
      for (int r = 0; r < 8; r++) begin
         b = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(7)) : 32'($urandom);
         n = 16'($urandom_range(12, 1));
         rdy = $urandom_range(100, 30);
         do_xfer(b, n, rdy, 3);
         total++; if (timed_out || done_cnt != 1) begin bad++; $display("FAIL rnd%0d_done got=%0d exp=1", r, done_cnt); end
         total++; if (beat_data.size() != int'(n)) begin bad++; $display("FAIL rnd%0d_beats got=%0d exp=%0d", r, beat_data.size(), n); end
         total++; if (max_ahead > DEPTH) begin bad++; $display("FAIL rnd%0d_credit got=%0d exp<=%0d", r, max_ahead, DEPTH); end
         for (int i = 0; i < beat_data.size(); i++) begin
            total++;
            if (beat_data[i] !== exp_word(mem_word(b + 32'(i))) || beat_last[i] !== (i == int'(n) - 1)) begin
               bad++; $display("FAIL rnd%0d_beat%0d got=%h/%b exp=%h/%b", r, i, beat_data[i], beat_last[i],
                               exp_word(mem_word(b + 32'(i))), (i == int'(n) - 1));
            end
         end
         if (beat_cyc.size() == int'(n)) begin
            total++;
            if (done_cyc != beat_cyc[n - 1] + 1) begin bad++; $display("FAIL rnd%0d_done_cyc got=%0d exp=%0d", r, done_cyc, beat_cyc[n - 1] + 1); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_reset_abort();
      test_byte_order();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
